lcd_write_sequencer: RTL and testbench
======================================

LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/DB are stable before EN rises (>=1).
REQ-002 Parameter EN_CYC, default 25: EN high pulse width in cycles (>=1).
REQ-003 Parameter HOLD_CYC, default 2: cycles RS/DB are held after EN falls (>=1).
REQ-004 Parameter WAIT_CYC, default 2500: post-write execution delay for normal commands/data (>=1).
REQ-005 Parameter LONG_WAIT_CYC, default 82000: post-write delay for clear/home commands (>=1).
REQ-006 clk_clk  input  1  single system clock; all logic on rising edge.
REQ-007 reset_reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream byte request valid.
REQ-009 in_ready  output  1  sequencer can accept a byte this cycle.
REQ-010 in_rs  input  1  register select for the byte: 0 = command, 1 = data.
REQ-011 in_data  input  8  byte to write to the LCD.
REQ-012 busy  output  1  high whenever the sequencer is not in IDLE.
REQ-013 lcd_db  output  8  LCD data bus.
REQ-014 lcd_rs  output  1  LCD register select.
REQ-015 lcd_rw  output  1  LCD read/write; always 0 (write-only).
REQ-016 lcd_en  output  1  LCD enable strobe.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ENABLE, HOLD, WAIT; one shared down/up counter times each state.
REQ-018 in_ready SHALL equal (state == IDLE); a transfer occurs only on a cycle with in_valid && in_ready.
REQ-019 On transfer at cycle T, in_rs/in_data SHALL be registered, driven on lcd_rs/lcd_db from T+1, and the FSM SHALL enter SETUP at T+1.
REQ-020 SETUP SHALL last exactly SETUP_CYC cycles with lcd_en = 0, then go to ENABLE.
REQ-021 ENABLE SHALL last exactly EN_CYC cycles with lcd_en = 1, then go to HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYC cycles with lcd_en = 0, then go to WAIT.
REQ-023 WAIT SHALL last LONG_WAIT_CYC cycles if the captured rs = 0 and byte is 0x01, 0x02 or 0x03, else WAIT_CYC cycles, then go to IDLE.
REQ-024 lcd_rs/lcd_db SHALL remain constant from T+1 until the next transfer (not only through HOLD).
REQ-025 IDLE SHALL be re-entered at cycle T+1+SETUP_CYC+EN_CYC+HOLD_CYC+wait; in_ready high that same cycle.
REQ-026 in_valid while not ready SHALL be ignored; no input is sampled outside IDLE; no queuing.
REQ-027 Back-to-back: in_valid held high SHALL cause a new transfer on the first IDLE cycle, giving no extra bubble.
REQ-028 lcd_en SHALL be a registered output, glitch-free, high only in ENABLE.
REQ-029 lcd_rw SHALL be constant 0 in every state including reset.

Reset
REQ-030 While reset_reset = 1 at a clock edge: state <= IDLE, counter <= 0, lcd_en <= 0, lcd_rs <= 0, lcd_db <= 0x00, busy <= 0.
REQ-031 in_ready SHALL be 0 during any cycle in which reset_reset = 1.
REQ-032 Reset mid-operation (any state, including ENABLE) SHALL drop lcd_en to 0 on the next edge and abandon the write; no resumption.
REQ-033 Reset has priority over a simultaneous in_valid; the byte is not accepted.

Verification (SETUP=2, EN=3, HOLD=1, WAIT=4, LONG=10)
REQ-034 Reset 3 cycles -> lcd_en=0, lcd_rs=0, lcd_db=0x00, lcd_rw=0, busy=0; in_ready=1 on first cycle after reset released.
REQ-035 Data write rs=1, 0x41 accepted at cycle 0 -> lcd_rs=1, lcd_db=0x41 from cycle 1; lcd_en=1 cycles 3-5 only; in_ready=1 again at cycle 11.
REQ-036 Command rs=0, 0x01 at cycle 0 -> lcd_en=1 cycles 3-5; WAIT cycles 7-16; in_ready=1 at cycle 17; rs=1, 0x01 uses short wait (ready at 11).
REQ-037 in_valid held high with 3 bytes 0x38, 0x0C, 0x06 -> accepted at cycles 0, 11, 22; each produces exactly one 3-cycle EN pulse; inputs changed while busy have no effect.
REQ-038 Assert reset at cycle 4 (inside ENABLE) -> lcd_en=0 at cycle 5, state IDLE, lcd_db=0x00; a new byte presented after release is sequenced with full timing.
REQ-039 Assertions throughout: lcd_rw==0; lcd_db/lcd_rs stable whenever lcd_en==1 and for one cycle before its rise and after its fall; busy == !in_ready outside reset.

Source files
------------

// File: rtl/lcd_write_sequencer_if.sv
// Handshake and LCD pin bundle for lcd_write_sequencer.
//   in_valid/in_ready/in_rs/in_data : upstream byte request (valid/ready)
//   busy                            : sequencer not idle
//   lcd_db/lcd_rs/lcd_rw/lcd_en     : HD44780-style LCD write pins
// master = upstream producer / observer, slave = the sequencer.
interface lcd_write_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       busy;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_db, lcd_rs, lcd_rw, lcd_en
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_db, lcd_rs, lcd_rw, lcd_en
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Sequences one byte write to a character LCD: setup, EN pulse, hold, then
// an execution wait (long for clear/home commands) before accepting the
// next byte.
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   bus         : lcd_write_sequencer_if.slave (handshake + LCD pins)
module lcd_write_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2500,
  parameter int LONG_WAIT_CYC = 82000
) (
  input logic                  clk_clk,
  input logic                  reset_reset,
  lcd_write_sequencer_if.slave bus
);

  // Counter sized for the longest phase.
  localparam int MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_B = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D = (MAX_C > LONG_WAIT_CYC) ? MAX_C : LONG_WAIT_CYC;
  localparam int CW    = $clog2(MAX_D + 1);

  // Each phase loads N-1 and leaves when the counter reaches zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rs_q;
  logic [7:0]    db_q;
  logic          en_q;
  logic          long_cmd;

  // Clear display (0x01) and return home (0x02/0x03) need the long delay.
  assign long_cmd = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

  assign bus.in_ready = (state == IDLE) && !reset_reset;
  assign bus.busy     = (state != IDLE);
  assign bus.lcd_db   = db_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_rw   = 1'b0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
      cnt   <= '0;
      rs_q  <= 1'b0;
      db_q  <= 8'h00;
      en_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rs_q  <= bus.in_rs;
            db_q  <= bus.in_data;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= EN_LD;
            en_q  <= 1'b1;
            state <= ENABLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            cnt   <= HOLD_LD;
            en_q  <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= long_cmd ? LONG_LD : WAIT_LD;
            state <= WAIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
module tb_lcd_write_sequencer;
  localparam int S = 2, E = 3, H = 1, W = 4, L = 10;
  localparam int TOT_S = 1 + S + E + H + W;
  localparam int TOT_L = 1 + S + E + H + L;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t exp_q[$];

  lcd_write_sequencer_if bus();

  lcd_write_sequencer #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .WAIT_CYC(W), .LONG_WAIT_CYC(L)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: continuous pin checks plus EN pulse capture and scoreboard pop.
  logic       en_prev = 1'b0;
  logic       rst_prev = 1'b1;
  logic       rs_prev = 1'b0;
  logic [7:0] db_prev = 8'h00;
  logic       in_pulse = 1'b0;
  int         p_start = 0;
  int         p_width = 0;
  logic       p_rs = 1'b0;
  logic [7:0] p_db = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if (bus.lcd_rw !== 1'b0) begin
      n_fails++; $display("FAIL rw_zero: got %b want 0 at cycle %0d", bus.lcd_rw, cyc);
    end
    if (!rst) begin
      n_checks++;
      if (bus.busy !== !bus.in_ready) begin
        n_fails++; $display("FAIL busy_vs_ready: busy=%b in_ready=%b at cycle %0d", bus.busy, bus.in_ready, cyc);
      end
    end
    if (!rst && !rst_prev && (bus.lcd_en || en_prev)) begin
      n_checks++;
      if (bus.lcd_db !== db_prev || bus.lcd_rs !== rs_prev) begin
        n_fails++;
        $display("FAIL bus_stable: db=%h rs=%b, previous db=%h rs=%b at cycle %0d",
                 bus.lcd_db, bus.lcd_rs, db_prev, rs_prev, cyc);
      end
    end
    if (rst) begin
      in_pulse = 1'b0;  // a pulse cut by reset is abandoned, not scored
    end else if (bus.lcd_en && !en_prev) begin
      in_pulse = 1'b1; p_start = cyc; p_width = 1; p_rs = bus.lcd_rs; p_db = bus.lcd_db;
    end else if (bus.lcd_en && in_pulse) begin
      p_width++;
    end else if (!bus.lcd_en && en_prev && in_pulse) begin
      in_pulse = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++; $display("FAIL sb_unexpected_pulse: db=%h rs=%b started cycle %0d, want none", p_db, p_rs, p_start);
      end else begin
        e = exp_q.pop_front();
        if (p_rs !== e.rs || p_db !== e.data) begin
          n_fails++; $display("FAIL sb_bytes: got rs=%b db=%h want rs=%b db=%h", p_rs, p_db, e.rs, e.data);
        end
        n_checks++;
        if (p_start != e.t0 + 1 + S) begin
          n_fails++; $display("FAIL sb_en_rise: got cycle %0d want %0d", p_start, e.t0 + 1 + S);
        end
        n_checks++;
        if (p_width != E) begin
          n_fails++; $display("FAIL sb_en_width: got %0d want %0d", p_width, E);
        end
      end
    end
    en_prev  = bus.lcd_en;
    rst_prev = rst;
    rs_prev  = bus.lcd_rs;
    db_prev  = bus.lcd_db;
  end

  // Present one byte for a single cycle; optionally record it as expected.
  task automatic drive_byte(input logic rs, input logic [7:0] d, input bit push,
                            output int t0, output logic acc);
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_data = d;
    t0 = cyc;
    if (push) begin
      e.rs = rs; e.data = d; e.t0 = t0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    acc = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_rs = 1'($urandom); bus.in_data = 8'($urandom);
  endtask

  // Returns the cycle in_ready is seen high, or -1 on timeout.
  task automatic wait_ready(output int rc);
    rc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        rc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'hFF;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fails++; $display("FAIL reset_ready_low: got %b want 0", bus.in_ready);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.lcd_en !== 1'b0 || bus.lcd_rs !== 1'b0 || bus.lcd_db !== 8'h00 || bus.busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: en=%b rs=%b db=%h busy=%b want 0 0 00 0",
               bus.lcd_en, bus.lcd_rs, bus.lcd_db, bus.busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fails++; $display("FAIL reset_ready_after: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_wait_select;
    logic       rs_t [6];
    logic [7:0] d_t  [6];
    int t0, rc, expc;
    logic acc;
    rs_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    d_t  = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h01, 8'h04};
    for (int i = 0; i < 6; i++) begin
      drive_byte(rs_t[i], d_t[i], 1'b1, t0, acc);
      n_checks++;
      if (acc !== 1'b1) begin
        n_fails++; $display("FAIL ws_accept[%0d]: in_ready=%b want 1", i, acc);
      end
      wait_ready(rc);
      expc = t0 + ((!rs_t[i] && d_t[i] >= 8'h01 && d_t[i] <= 8'h03) ? TOT_L : TOT_S);
      n_checks++;
      if (rc != expc) begin
        n_fails++; $display("FAIL ws_ready_cycle[%0d]: got %0d want %0d", i, rc, expc);
      end
      n_checks++;
      if (bus.lcd_db !== d_t[i] || bus.lcd_rs !== rs_t[i]) begin
        n_fails++;
        $display("FAIL ws_bus_held[%0d]: db=%h rs=%b want db=%h rs=%b",
                 i, bus.lcd_db, bus.lcd_rs, d_t[i], rs_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [3];
    exp_t e;
    int t, rc;
    b = '{8'h38, 8'h0C, 8'h06};
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_rs = 1'b0; bus.in_data = b[0];
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      e.rs = 1'b0; e.data = b[i]; e.t0 = t;
      exp_q.push_back(e);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fails++; $display("FAIL b2b_accept[%0d]: in_ready=%b want 1 at cycle %0d", i, bus.in_ready, cyc);
      end
      @(posedge clk); #1;
      // Junk on the inputs while busy must be ignored.
      bus.in_rs = 1'b1; bus.in_data = 8'($urandom);
      if (i < 2) begin
        repeat (TOT_S - 1) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fails++; $display("FAIL b2b_early_ready[%0d]: in_ready=%b want 0 at cycle %0d", i, bus.in_ready, cyc);
        end
        bus.in_rs = 1'b0; bus.in_data = b[i+1];
        @(posedge clk); #1;
        t = cyc;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    wait_ready(rc);
    n_checks++;
    if (rc != t + TOT_S) begin
      n_fails++; $display("FAIL b2b_final_ready: got %0d want %0d", rc, t + TOT_S);
    end
  endtask

  task automatic test_reset_mid;
    int t0, rc;
    logic acc;
    drive_byte(1'b1, 8'hA5, 1'b0, t0, acc);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;   // now in cycle t0+4, inside ENABLE
    @(negedge clk);
    n_checks++;
    if (bus.lcd_en !== 1'b1) begin
      n_fails++; $display("FAIL rmid_en_before: got %b want 1 at cycle %0d", bus.lcd_en, cyc - t0);
    end
    @(negedge clk);
    n_checks++;
    if (bus.lcd_en !== 1'b0 || bus.lcd_db !== 8'h00 || bus.lcd_rs !== 1'b0 || bus.busy !== 1'b0) begin
      n_fails++;
      $display("FAIL rmid_after: en=%b db=%h rs=%b busy=%b want 0 00 0 0",
               bus.lcd_en, bus.lcd_db, bus.lcd_rs, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.lcd_en !== 1'b0) begin
      n_fails++; $display("FAIL rmid_release: in_ready=%b en=%b want 1 0", bus.in_ready, bus.lcd_en);
    end
    drive_byte(1'b1, 8'h55, 1'b1, t0, acc);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fails++; $display("FAIL rmid_accept: in_ready=%b want 1", acc);
    end
    wait_ready(rc);
    n_checks++;
    if (rc != t0 + TOT_S) begin
      n_fails++; $display("FAIL rmid_ready_cycle: got %0d want %0d", rc, t0 + TOT_S);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_rs = 1'b0; bus.in_data = 8'h00;
    test_reset();
    test_wait_select();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++; $display("FAIL sb_missing_pulses: %0d outstanding want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
